aes_key_expand: RTL and testbench

//  Sequential AES key-schedule engine, parametrised for AES-128/192/256. Accepts a cipher key over a

---
 rtl/aes_key_pkg.sv | 19 +
 rtl/aes_sbox_byte.sv | 28 ++
 rtl/aes_key_expand.sv | 144 ++++++++++++++
 tb/tb_aes_key_expand.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_pkg.sv
// aes_key_pkg: shared state encoding, round-key type and helpers for the AES key-schedule engine.
package aes_key_pkg;
    typedef enum logic [1:0] {IDLE, GEN, STALL, DRAIN} state_e;
    typedef logic [127:0] rkey_t;
    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction
    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction
    // Rcon[n] = x^(n-1) in GF(2^8), n = 1..10
    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < 10; k++)
            if (4'(k) < n) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
        return r;
    endfunction
endpackage

// File: rtl/aes_sbox_byte.sv
// aes_sbox_byte: combinational AES S-box, multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox_byte (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    logic [7:0] sq, inv;
    // inv = x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0
    always_comb begin
        sq = gmul(in_byte, in_byte);
        inv = sq;
        for (int k = 2; k < 8; k++) begin
            sq = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: streams AES-128/192/256 round keys 0..NR, one schedule word per cycle.
// Define AES_KEY_STORE_EN to add an addressable (NR+1)x128 round-key store for reverse-order reads.
module aes_key_expand
    import aes_key_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [3:0]          rk_idx,
    output logic                rk_last,
    output logic                busy
`ifdef AES_KEY_STORE_EN
    ,
    input  logic [3:0]          rd_idx,
    output logic [127:0]        rd_key,
    output logic                store_valid
`endif
);
    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam int LAST = 4 * NR + 3;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_expand: KEY_BITS must be 128, 192 or 256");
    end

    state_e              state_q, state_d;
    logic                key_ready_q, key_ready_d, busy_q, busy_d;
    logic                rk_valid_q, rk_valid_d, rk_last_q, rk_last_d;
    rkey_t               rk_data_q, rk_data_d;
    logic [3:0]          rk_idx_q, rk_idx_d;
    logic [5:0]          i_q, i_d;
    logic [2:0]          j_q, j_d;
    logic [3:0]          r_q, r_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [NK*32-1:0]    win_q, win_d;
    logic [31:0]         prev, sub_in, sub_out, t, word;
    logic                accept, gen, blocked, adv, load, done;

    // win_q holds w[i-NK] in its top word and w[i-1] in its bottom word; j = i%NK, r = i/NK
    assign prev    = win_q[31:0];
    assign sub_in  = (j_q == '0) ? {prev[23:0], prev[31:24]} : prev;
    assign accept  = state_q == IDLE && key_valid && key_ready_q;
    assign gen     = state_q == GEN || state_q == STALL;
    assign blocked = i_q[1:0] == 2'd3 && rk_valid_q && !rk_ready;
    assign adv     = gen && !blocked;
    assign load    = adv && i_q[1:0] == 2'd3;
    assign done    = adv && i_q == 6'(LAST);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox_byte u_sbox (.in_byte(sub_in[8*g +: 8]), .out_byte(sub_out[8*g +: 8]));
    end

    always_comb begin
        t = (j_q == '0) ? sub_out ^ {rcon(r_q), 24'h0} : (NK == 8 && j_q == 3'd4) ? sub_out : prev;
        word = (r_q == '0) ? key_q[KEY_BITS-1 -: 32] : win_q[NK*32-1 -: 32] ^ t;
        i_d = accept ? '0 : adv ? i_q + 6'd1 : i_q;
        j_d = accept ? '0 : adv ? (j_q == 3'(NK-1) ? '0 : j_q + 3'd1) : j_q;
        r_d = accept ? '0 : (adv && j_q == 3'(NK-1)) ? r_q + 4'd1 : r_q;
        key_d = accept ? key_in : adv ? key_q << 32 : key_q;
        win_d = adv ? {win_q[NK*32-33:0], word} : win_q;
        state_d = (state_q == IDLE)  ? (accept ? GEN : IDLE)
                : (state_q == DRAIN) ? ((rk_valid_q && rk_ready) ? IDLE : DRAIN)
                : done ? DRAIN : blocked ? STALL : GEN;
        rk_valid_d = load || (rk_valid_q && !rk_ready);
        rk_data_d = load ? {win_q[95:0], word} : rk_data_q;
        rk_idx_d = load ? i_q[5:2] : rk_idx_q;
        rk_last_d = load ? done : rk_last_q;
        key_ready_d = state_d == IDLE;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rk_valid_q  <= 1'b0;
            rk_data_q   <= '0;
            rk_idx_q    <= '0;
            rk_last_q   <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            r_q         <= '0;
            key_q       <= '0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            key_ready_q <= key_ready_d;
            busy_q      <= busy_d;
            rk_valid_q  <= rk_valid_d;
            rk_data_q   <= rk_data_d;
            rk_idx_q    <= rk_idx_d;
            rk_last_q   <= rk_last_d;
            i_q         <= i_d;
            j_q         <= j_d;
            r_q         <= r_d;
            key_q       <= key_d;
            win_q       <= win_d;
        end
    end

    assign key_ready = key_ready_q;
    assign busy      = busy_q;
    assign rk_valid  = rk_valid_q;
    assign rk_data   = rk_data_q;
    assign rk_idx    = rk_idx_q;
    assign rk_last   = rk_last_q;

`ifdef AES_KEY_STORE_EN
    rkey_t store_q [NR+1];
    rkey_t rd_key_q, rd_key_d;
    logic  store_valid_q, store_valid_d;

    always_comb begin
        rd_key_d = (rd_idx <= 4'(NR)) ? store_q[rd_idx] : '0;
        store_valid_d = accept ? 1'b0 : done ? 1'b1 : store_valid_q;
    end

    always_ff @(posedge clk) begin
        if (load) store_q[i_q[5:2]] <= rk_data_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_key_q      <= '0;
            store_valid_q <= 1'b0;
        end else begin
            rd_key_q      <= rd_key_d;
            store_valid_q <= store_valid_d;
        end
    end

    assign rd_key      = rd_key_q;
    assign store_valid = store_valid_q;
`endif
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: randomized key-schedule checks of AES-128/192/256 engines against an array-based FIPS-197 model.
module tb_aes_key_expand;
    logic         clk = 1'b0, rst_n = 1'b0, rk_ready = 1'b0;
    logic [255:0] key_bus = '0;
    logic [2:0]   kv = '0, kr, rv, rl, bsy;
    logic [127:0] rd [3];
    logic [3:0]   ri [3];
    logic [7:0]   sbox [256];
    logic [7:0]   rcon_tab [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] exp_rk [15];
    logic [127:0] got_d [15];
    logic [3:0]   got_i [15];
    logic         got_l [15];
    int got_n, first_cyc, last_cyc, stab_err, waited;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    aes_key_expand #(.KEY_BITS(128)) u_a (
        .clk(clk), .rst_n(rst_n), .key_valid(kv[0]), .key_ready(kr[0]), .key_in(key_bus[255:128]),
        .rk_valid(rv[0]), .rk_ready(rk_ready), .rk_data(rd[0]), .rk_idx(ri[0]), .rk_last(rl[0]), .busy(bsy[0]));
    aes_key_expand #(.KEY_BITS(192)) u_b (
        .clk(clk), .rst_n(rst_n), .key_valid(kv[1]), .key_ready(kr[1]), .key_in(key_bus[255:64]),
        .rk_valid(rv[1]), .rk_ready(rk_ready), .rk_data(rd[1]), .rk_idx(ri[1]), .rk_last(rl[1]), .busy(bsy[1]));
    aes_key_expand #(.KEY_BITS(256)) u_c (
        .clk(clk), .rst_n(rst_n), .key_valid(kv[2]), .key_ready(kr[2]), .key_in(key_bus),
        .rk_valid(rv[2]), .rk_ready(rk_ready), .rk_data(rd[2]), .rk_idx(ri[2]), .rk_last(rl[2]), .busy(bsy[2]));

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sbox[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
    endfunction

    // key is left-aligned; fills exp_rk[0..nk+6]
    task automatic model(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[i-1];
            if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk], 24'h0};
            else if (nk == 8 && i % nk == 4) t = sub_word(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nk + 6; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic start(input int s, input logic [255:0] key);
        waited = 0;
        while (!kr[s] && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!kr[s]) begin
            checks++; errors++;
            $display("FAIL start_wait dut=%0d key_ready=%b expected 1", s, kr[s]);
        end
        key_bus = key;
        kv[s] = 1'b1;
        @(posedge clk); #1;
        kv[s] = 1'b0;
    endtask

    // cycle 0 is just after the accepting edge; records every accepted round key
    task automatic collect(input int s, input int nr, input int pct);
        logic pv, pr, pl;
        logic [127:0] pd;
        logic [3:0] pi;
        int cyc;
        got_n = 0; first_cyc = -1; last_cyc = -1; stab_err = 0; cyc = 0;
        pv = 1'b0; pr = 1'b1; pd = '0; pi = '0; pl = 1'b0;
        while (got_n < nr + 1 && cyc < 2000) begin
            if (pv && !pr && (!rv[s] || rd[s] !== pd || ri[s] !== pi || rl[s] !== pl)) stab_err++;
            rk_ready = ($urandom_range(99) < pct);
            if (rv[s] && first_cyc < 0) first_cyc = cyc;
            if (rv[s] && rk_ready) begin
                got_d[got_n] = rd[s]; got_i[got_n] = ri[s]; got_l[got_n] = rl[s];
                if (rl[s]) last_cyc = cyc;
                got_n++;
            end
            pv = rv[s]; pr = rk_ready; pd = rd[s]; pi = ri[s]; pl = rl[s];
            @(posedge clk); #1;
            cyc++;
        end
        rk_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (kr !== 3'b111) begin errors++; $display("FAIL reset_key_ready got %b want 111", kr); end
        checks++; if (rv !== 3'b000) begin errors++; $display("FAIL reset_rk_valid got %b want 000", rv); end
        checks++; if (rl !== 3'b000) begin errors++; $display("FAIL reset_rk_last got %b want 000", rl); end
        checks++; if (bsy !== 3'b000) begin errors++; $display("FAIL reset_busy got %b want 000", bsy); end
        checks++; if (rd[0] !== '0) begin errors++; $display("FAIL reset_rk_data got %h want 0", rd[0]); end
        checks++; if (ri[0] !== 4'd0) begin errors++; $display("FAIL reset_rk_idx got %0d want 0", ri[0]); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (kr !== 3'b111 || bsy !== 3'b000 || rv !== 3'b000) begin
            errors++; $display("FAIL idle_after_release kr=%b busy=%b rv=%b want 111/000/000", kr, bsy, rv);
        end
    endtask

    task automatic test_aes128_vector();
        logic [255:0] k;
        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        model(k, 4);
        start(0, k);
        collect(0, 10, 100);
        checks++; if (got_n !== 11) begin errors++; $display("FAIL v128_count got %0d want 11", got_n); end
        for (int r = 0; r < got_n; r++) begin
            checks++;
            if (got_d[r] !== exp_rk[r] || got_i[r] !== 4'(r) || got_l[r] !== (r == 10)) begin
                errors++; $display("FAIL v128_round%0d got %h idx %0d last %b want %h", r, got_d[r], got_i[r], got_l[r], exp_rk[r]);
            end
        end
        checks++; if (got_d[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++; $display("FAIL v128_rk1 got %h want a0fafe1788542cb123a339392a6c7605", got_d[1]);
        end
        checks++; if (got_d[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || got_l[10] !== 1'b1) begin
            errors++; $display("FAIL v128_rk10 got %h last %b want d014f9a8c9ee2589e13f0cc8b6630ca6 last 1", got_d[10], got_l[10]);
        end
        checks++; if (first_cyc !== 4) begin errors++; $display("FAIL v128_first_latency got %0d want 4", first_cyc); end
        checks++; if (last_cyc !== 44) begin errors++; $display("FAIL v128_last_latency got %0d want 44", last_cyc); end
        checks++; if (kr[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            errors++; $display("FAIL v128_ready_after kr=%b busy=%b want 1/0", kr[0], bsy[0]);
        end
    endtask

    task automatic test_long_keys();
        logic [255:0] k;
        logic [127:0] want_last;
        int nr;
        for (int s = 1; s < 3; s++) begin
            k = (s == 1) ? {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}
                         : 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
            want_last = (s == 1) ? 128'he98ba06f448c773c8ecc720401002202 : 128'hfe4890d1e6188d0b046df344706c631e;
            nr = (s == 1) ? 12 : 14;
            model(k, nr - 6);
            start(s, k);
            collect(s, nr, 100);
            checks++; if (got_n !== nr + 1) begin errors++; $display("FAIL long%0d_count got %0d want %0d", s, got_n, nr + 1); end
            for (int r = 0; r < got_n; r++) begin
                checks++;
                if (got_d[r] !== exp_rk[r] || got_i[r] !== 4'(r) || got_l[r] !== (r == nr)) begin
                    errors++; $display("FAIL long%0d_round%0d got %h idx %0d last %b want %h", s, r, got_d[r], got_i[r], got_l[r], exp_rk[r]);
                end
            end
            checks++; if (got_d[nr] !== want_last) begin errors++; $display("FAIL long%0d_final got %h want %h", s, got_d[nr], want_last); end
            checks++; if (last_cyc !== 4 * nr + 4) begin errors++; $display("FAIL long%0d_latency got %0d want %0d", s, last_cyc, 4 * nr + 4); end
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] k;
        int nr;
        for (int s = 0; s < 3; s++) begin
            nr = 10 + 2 * s;
            for (int n = 0; n < 2; n++) begin
                k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                model(k, nr - 6);
                start(s, k);
                key_bus = ~k;
                kv[s] = 1'b1;
                collect(s, nr, 30);
                kv[s] = 1'b0;
                checks++; if (got_n !== nr + 1) begin errors++; $display("FAIL bp%0d_count got %0d want %0d", s, got_n, nr + 1); end
                for (int r = 0; r < got_n; r++) begin
                    checks++;
                    if (got_d[r] !== exp_rk[r] || got_i[r] !== 4'(r) || got_l[r] !== (r == nr)) begin
                        errors++; $display("FAIL bp%0d_round%0d got %h idx %0d last %b want %h", s, r, got_d[r], got_i[r], got_l[r], exp_rk[r]);
                    end
                end
                checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp%0d_stability unstable_cycles %0d want 0", s, stab_err); end
                checks++; if (kr[s] !== 1'b1 || bsy[s] !== 1'b0) begin
                    errors++; $display("FAIL bp%0d_key_valid_ignored kr=%b busy=%b want 1/0", s, kr[s], bsy[s]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] k;
        for (int n = 0; n < 3; n++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
            model(k, 4);
            start(0, k);
            checks++; if (waited !== 0) begin errors++; $display("FAIL b2b%0d_accept_wait got %0d want 0", n, waited); end
            collect(0, 10, 100);
            checks++; if (got_n !== 11 || first_cyc !== 4 || last_cyc !== 44) begin
                errors++; $display("FAIL b2b%0d_timing count %0d first %0d last %0d want 11/4/44", n, got_n, first_cyc, last_cyc);
            end
            for (int r = 0; r < got_n; r++) begin
                checks++;
                if (got_d[r] !== exp_rk[r] || got_i[r] !== 4'(r)) begin
                    errors++; $display("FAIL b2b%0d_round%0d got %h idx %0d want %h", n, r, got_d[r], got_i[r], exp_rk[r]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [255:0] k;
        k = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
        start(0, k);
        rk_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (rv[0] !== 1'b0 || rl[0] !== 1'b0 || bsy[0] !== 1'b0 || kr[0] !== 1'b1) begin
            errors++; $display("FAIL mid_reset_ctrl rv=%b last=%b busy=%b kr=%b want 0/0/0/1", rv[0], rl[0], bsy[0], kr[0]);
        end
        checks++; if (rd[0] !== '0 || ri[0] !== 4'd0) begin
            errors++; $display("FAIL mid_reset_data got %h idx %0d want 0/0", rd[0], ri[0]);
        end
        @(posedge clk); #1;
        checks++; if (rv[0] !== 1'b0 || bsy[0] !== 1'b0) begin
            errors++; $display("FAIL mid_reset_hold rv=%b busy=%b want 0/0", rv[0], bsy[0]);
        end
        rst_n = 1'b1;
        rk_ready = 1'b0;
        #2;
        k = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
        model(k, 4);
        start(0, k);
        collect(0, 10, 100);
        checks++; if (first_cyc !== 4 || got_n !== 11) begin
            errors++; $display("FAIL mid_reset_restart first %0d count %0d want 4/11", first_cyc, got_n);
        end
        checks++; if (got_d[0] !== exp_rk[0] || got_i[0] !== 4'd0) begin
            errors++; $display("FAIL mid_reset_round0 got %h idx %0d want %h", got_d[0], got_i[0], exp_rk[0]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        build_sbox();
        test_reset();
        test_aes128_vector();
        test_long_keys();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
